// File: rtl/key_off_cfg_sched.sv
// Schedules key-offset config writes into per-stage key-extract offset RAMs.
// Requests pass through an in-order FIFO and are issued one strobe per cycle, with per-stage stalls and bulk clear.
module key_off_cfg_sched #(
  parameter int NUM_STAGES         = 5,
  parameter int AXIL_WIDTH         = 32,
  parameter int KEY_OFF            = 18,
  parameter int KEY_OFF_ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic                          cfg_clear,
  input  logic [2:0]                    cfg_stage,
  input  logic [KEY_OFF_ADDR_WIDTH-1:0] cfg_addr,
  input  logic [AXIL_WIDTH-1:0]         cfg_data,
  input  logic [NUM_STAGES-1:0]         stage_busy,
  output logic [AXIL_WIDTH-1:0]         key_off_entry_out,
  output logic [KEY_OFF_ADDR_WIDTH-1:0] key_off_entry_addr_out,
  output logic [NUM_STAGES-1:0]         key_off_entry_valid_out,
  output logic                          cfg_err,
  output logic                          cfg_idle,
  output logic [15:0]                   wr_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [3:0] NUM_STAGES_L = 4'(NUM_STAGES);
  localparam logic [KEY_OFF_ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {IDLE, ISSUE, CLEAR} state_e;

  typedef struct packed {
    logic                          clear;
    logic [2:0]                    stage;
    logic [KEY_OFF_ADDR_WIDTH-1:0] addr;
    logic [KEY_OFF-1:0]            data;
  } entry_t;

  state_e                        state_q, state_d;
  entry_t                        mem_q [FIFO_DEPTH];
  entry_t                        mem_d [FIFO_DEPTH];
  logic [PTR_W:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_ptr_nxt;
  logic [KEY_OFF_ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic [AXIL_WIDTH-1:0]         entry_q, entry_d;
  logic [KEY_OFF_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [NUM_STAGES-1:0]         valid_q, valid_d;
  logic                          err_q, err_d;
  logic [15:0]                   wr_count_q, wr_count_d;

  logic   fifo_full, fifo_empty, accept, bad_stage, push, pop, head_busy;
  entry_t head;
  logic [7:0] busy_ext;
  logic   unused_data;

  // Handshake: a request transfers on any cycle where cfg_valid && cfg_ready;
  // cfg_ready depends only on registered FIFO occupancy (no same-cycle bypass).
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head       = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign busy_ext   = 8'(stage_busy);
  assign head_busy  = busy_ext[head.stage];
  assign rd_ptr_nxt = rd_ptr_q + 1'b1;
  assign unused_data = ^cfg_data[AXIL_WIDTH-1:KEY_OFF];

  always_comb begin
    accept    = cfg_valid && !fifo_full;
    bad_stage = ({1'b0, cfg_stage} >= NUM_STAGES_L);
    push      = accept && !bad_stage;
    err_d     = accept && bad_stage;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = '{clear: cfg_clear, stage: cfg_stage,
                                     addr: cfg_addr, data: cfg_data[KEY_OFF-1:0]};
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    pop        = 1'b0;
    state_d    = state_q;
    valid_d    = '0;
    entry_d    = entry_q;
    addr_d     = addr_q;
    clr_addr_d = clr_addr_q;

    // IDLE and ISSUE both decide on the head so an entry reaching an empty FIFO issues without a dead cycle.
    case (state_q)
      IDLE, ISSUE: begin
        if (fifo_empty) begin
          state_d = IDLE;
        end else if (head.clear) begin
          clr_addr_d = '0;
          state_d    = CLEAR;
        end else if (!head_busy) begin
          valid_d = NUM_STAGES'(1) << head.stage;
          addr_d  = head.addr;
          entry_d = AXIL_WIDTH'(head.data);
          pop     = 1'b1;
          state_d = (rd_ptr_nxt != wr_ptr_d) ? ISSUE : IDLE;
        end else begin
          state_d = ISSUE;
        end
      end
      CLEAR: begin
        if (!head_busy) begin
          valid_d = NUM_STAGES'(1) << head.stage;
          addr_d  = clr_addr_q;
          entry_d = '0;
          if (clr_addr_q == LAST_ADDR) begin
            pop     = 1'b1;
            state_d = IDLE;
          end else begin
            clr_addr_d = clr_addr_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    rd_ptr_d   = pop ? rd_ptr_nxt : rd_ptr_q;
    wr_count_d = wr_count_q;
    if ((valid_d != '0) && (wr_count_q != 16'hFFFF)) wr_count_d = wr_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      clr_addr_q <= '0;
      entry_q    <= '0;
      addr_q     <= '0;
      valid_q    <= '0;
      err_q      <= 1'b0;
      wr_count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      clr_addr_q <= clr_addr_d;
      entry_q    <= entry_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      wr_count_q <= wr_count_d;
      mem_q      <= mem_d;
    end
  end

  assign cfg_ready               = !fifo_full;
  assign key_off_entry_out       = entry_q;
  assign key_off_entry_addr_out  = addr_q;
  assign key_off_entry_valid_out = valid_q;
  assign cfg_err                 = err_q;
  assign wr_count                = wr_count_q;
  assign cfg_idle                = fifo_empty && (state_q == IDLE) && (valid_q == '0);

endmodule

// File: tb/tb_key_off_cfg_sched.sv
// Bench for key_off_cfg_sched: directed scenarios plus randomized traffic,
// checked by a scoreboard fed from a request-level reference model.
module tb_key_off_cfg_sched;
  localparam int NS = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_clear = 1'b0;
  logic [2:0]    cfg_stage = '0;
  logic [3:0]    cfg_addr = '0;
  logic [31:0]   cfg_data = '0;
  logic [NS-1:0] stage_busy;
  logic [NS-1:0] dir_busy = '0;
  logic [NS-1:0] rnd_busy = '0;
  logic          rand_mode = 1'b0;
  logic          cfg_ready, cfg_err, cfg_idle;
  logic [31:0]   key_off_entry_out;
  logic [3:0]    key_off_entry_addr_out;
  logic [NS-1:0] key_off_entry_valid_out;
  logic [15:0]   wr_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int model_cnt = 0;
  int last_accept_cyc = 0;
  logic [38:0] exp_q[$];
  int err_cyc_q[$];
  int strobe_cyc[$];

  assign stage_busy = rand_mode ? rnd_busy : dir_busy;

  key_off_cfg_sched #(
    .NUM_STAGES(NS), .AXIL_WIDTH(32), .KEY_OFF(18), .KEY_OFF_ADDR_WIDTH(4), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_clear(cfg_clear), .cfg_stage(cfg_stage), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .stage_busy(stage_busy), .key_off_entry_out(key_off_entry_out),
    .key_off_entry_addr_out(key_off_entry_addr_out),
    .key_off_entry_valid_out(key_off_entry_valid_out),
    .cfg_err(cfg_err), .cfg_idle(cfg_idle), .wr_count(wr_count)
  );

  // clock / reset block
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial forever begin
    @(negedge clk);
    #2;
    for (int i = 0; i < NS; i++) rnd_busy[i] = ($urandom_range(0, 3) == 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: each accepted request expands into the exact write sequence it must cause.
  task automatic model_accept(input logic clr, input logic [2:0] st, input logic [3:0] ad,
                              input logic [31:0] dt);
    if (st >= 3'(NS)) err_cyc_q.push_back(cyc + 1);
    else if (clr) for (int i = 0; i < 16; i++) exp_q.push_back({st, 4'(i), 32'h0});
    else exp_q.push_back({st, ad, dt & 32'h0003_FFFF});
  endtask

  // scoreboard monitor
  initial begin : monitor
    logic exp_err;
    logic [38:0] e;
    int idx;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        exp_err = (err_cyc_q.size() > 0) && (err_cyc_q[0] == cyc);
        if (exp_err) void'(err_cyc_q.pop_front());
        if (exp_err || cfg_err) check("cfg_err", 32'(cfg_err), 32'(exp_err));
        if (key_off_entry_valid_out != '0) begin
          strobe_cyc.push_back(cyc);
          check("strobe_onehot", 32'($onehot(key_off_entry_valid_out)), 32'd1);
          idx = 0;
          for (int i = 0; i < NS; i++) if (key_off_entry_valid_out[i]) idx = i;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: stage %0d addr %0d data 0x%0h, none expected (cycle %0d)",
                     idx, key_off_entry_addr_out, key_off_entry_out, cyc);
          end else begin
            e = exp_q.pop_front();
            model_cnt = (model_cnt < 65535) ? model_cnt + 1 : model_cnt;
            check("strobe_stage", 32'(idx), 32'(e[38:36]));
            check("strobe_addr", 32'(key_off_entry_addr_out), 32'(e[35:32]));
            check("strobe_data", key_off_entry_out, e[31:0]);
            check("wr_count", 32'(wr_count), 32'(model_cnt));
          end
        end
      end
    end
  end

  // driver tasks (all called at posedge + 1)
  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_req(input logic clr, input logic [2:0] st, input logic [3:0] ad,
                          input logic [31:0] dt);
    int k = 0;
    cfg_valid = 1'b1; cfg_clear = clr; cfg_stage = st; cfg_addr = ad; cfg_data = dt;
    while (!cfg_ready && k < 500) begin @(posedge clk); #1; k++; end
    if (!cfg_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: cfg_ready stayed 0, required 1 within 500 cycles");
    end else begin
      model_accept(clr, st, ad, dt);
      last_accept_cyc = cyc;
      @(posedge clk); #1;
    end
    cfg_valid = 1'b0;
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int k = 0;
    while (strobe_cyc.size() < n && k < budget) begin @(negedge clk); #1; k++; end
    checks++;
    if (strobe_cyc.size() < n) begin
      errors++;
      $display("FAIL strobe_timeout: saw %0d strobes, required %0d", strobe_cyc.size(), n);
    end
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin @(posedge clk); #1; k++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d writes outstanding, required 0", exp_q.size());
    end
    idle_cycles(2);
    check("err_pending", 32'(err_cyc_q.size()), 32'd0);
    check("cfg_idle_after_drain", 32'(cfg_idle), 32'd1);
  endtask

  initial begin : stimulus
    logic [31:0] d [6];
    int cnt_before;

    // reset values
    #12;
    check("rst_ready", 32'(cfg_ready), 32'd1);
    check("rst_idle", 32'(cfg_idle), 32'd1);
    check("rst_valid", 32'(key_off_entry_valid_out), 32'd0);
    check("rst_err", 32'(cfg_err), 32'd0);
    check("rst_wr_count", 32'(wr_count), 32'd0);
    check("rst_entry", key_off_entry_out, 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // single write and latency
    strobe_cyc.delete();
    send_req(1'b0, 3'd2, 4'd5, 32'hFFFC_1234);
    drain(50);
    check("latency", 32'(strobe_cyc[0] - last_accept_cyc), 32'd2);
    check("single_wr_count", 32'(wr_count), 32'd1);

    // fill and backpressure
    strobe_cyc.delete();
    dir_busy = 5'b00001;
    for (int i = 0; i < 6; i++) d[i] = $urandom;
    for (int i = 0; i < 4; i++) send_req(1'b0, 3'd0, 4'(i), d[i]);
    cfg_valid = 1'b1; cfg_clear = 1'b0; cfg_stage = 3'd0; cfg_addr = 4'd4; cfg_data = d[4];
    check("ready_low_full", 32'(cfg_ready), 32'd0);
    idle_cycles(3);
    check("ready_low_held", 32'(cfg_ready), 32'd0);
    check("no_strobe_busy", 32'(strobe_cyc.size()), 32'd0);
    dir_busy = '0;
    send_req(1'b0, 3'd0, 4'd4, d[4]);
    send_req(1'b0, 3'd0, 4'd5, d[5]);
    drain(50);
    for (int i = 1; i < 4; i++) check("consecutive", 32'(strobe_cyc[i] - strobe_cyc[i-1]), 32'd1);

    // bad stage
    cnt_before = model_cnt;
    send_req(1'b0, 3'd6, 4'd3, $urandom);
    idle_cycles(5);
    check("bad_stage_count", 32'(wr_count), 32'(cnt_before));
    drain(20);

    // clear with a 3-cycle stall after the 8th write, write queued behind
    strobe_cyc.delete();
    send_req(1'b1, 3'd4, 4'd7, $urandom);
    send_req(1'b0, 3'd2, 4'd9, $urandom);
    wait_strobes(8, 100);
    dir_busy = 5'b10000;
    repeat (3) @(negedge clk);
    #1 dir_busy = '0;
    @(posedge clk); #1;
    drain(100);
    check("clear_strobes", 32'(strobe_cyc.size()), 32'd17);
    check("clear_gap", 32'(strobe_cyc[8] - strobe_cyc[7]), 32'd4);

    // head-of-line blocking
    strobe_cyc.delete();
    dir_busy = 5'b00010;
    send_req(1'b0, 3'd1, 4'd7, $urandom);
    send_req(1'b0, 3'd3, 4'd8, $urandom);
    idle_cycles(10);
    check("hol_blocked", 32'(strobe_cyc.size()), 32'd0);
    dir_busy = '0;
    drain(50);

    // reset in the middle of a clear with writes queued
    strobe_cyc.delete();
    send_req(1'b1, 3'd0, 4'd0, 32'd0);
    send_req(1'b0, 3'd1, 4'd2, $urandom);
    send_req(1'b0, 3'd2, 4'd3, $urandom);
    wait_strobes(6, 100);
    rst_n = 1'b0;
    exp_q.delete();
    err_cyc_q.delete();
    model_cnt = 0;
    #1;
    check("mid_rst_valid", 32'(key_off_entry_valid_out), 32'd0);
    check("mid_rst_ready", 32'(cfg_ready), 32'd1);
    check("mid_rst_idle", 32'(cfg_idle), 32'd1);
    check("mid_rst_wr_count", 32'(wr_count), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    idle_cycles(40);
    check("post_rst_strobes", 32'(strobe_cyc.size()), 32'd6);
    check("post_rst_idle", 32'(cfg_idle), 32'd1);
    check("post_rst_wr_count", 32'(wr_count), 32'd0);

    // randomized traffic with random stalls
    rand_mode = 1'b1;
    for (int n = 0; n < 300; n++) begin
      logic [2:0] st;
      st = ($urandom_range(0, 15) < 14) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      send_req(($urandom_range(0, 19) == 0), st, 4'($urandom_range(0, 15)), $urandom);
      idle_cycles($urandom_range(0, 2));
    end
    drain(3000);
    rand_mode = 1'b0;
    check("final_wr_count", 32'(wr_count), 32'(model_cnt));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
